// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges the single-cycle ALU write path with a small
// in-order queue of memory/long-latency writes onto one register-file write
// port. The queue is protected from starvation by a saturating loss counter,
// and decode can ask whether a source register still has a write in flight.

// Per-slot hazard comparator: one instance per queue entry.
module wb_slot_match (
  input  logic       vld,
  input  logic [4:0] rd,
  input  logic [4:0] qry1,
  input  logic [4:0] qry2,
  output logic       hit1,
  output logic       hit2
);
  assign hit1 = vld && (rd == qry1);
  assign hit2 = vld && (rd == qry2);
endmodule

module writeback_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        aluValid,
  output logic        aluReady,
  input  logic [4:0]  aluRd,
  input  logic [31:0] aluData,
  input  logic        memValid,
  output logic        memReady,
  input  logic [4:0]  memRd,
  input  logic [31:0] memData,
  input  logic [4:0]  readRegister1,
  input  logic [4:0]  readRegister2,
  output logic        hazard1,
  output logic        hazard2,
  output logic        regWrite,
  output logic [4:0]  writeRegister,
  output logic [31:0] writeData
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  // Only r1..r15 exist; r0 and anything with bit 4 set are sinks.
  function automatic logic writable(input logic [4:0] rd);
    return (rd != 5'd0) && !rd[4];
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // queue state
  wb_req_t [FIFO_DEPTH-1:0] q_ent;
  logic    [FIFO_DEPTH-1:0] q_vld;
  logic    [PW-1:0]         head;
  logic    [PW-1:0]         tail;
  logic    [CW-1:0]         count;
  logic    [3:0]            starve;

  // arbitration signals
  logic    q_empty;
  logic    forced;
  logic    alu_win;
  logic    q_win;
  logic    push;
  wb_req_t q_head;

  // Decide the single winner for this cycle from registered queue state.
  always_comb begin
    q_empty  = (count == '0);
    forced   = !q_empty && (starve == 4'(STARVE_LIMIT));
    // aluReady stays high through reset; requests are simply ignored then.
    aluReady = !rst_n || !forced;
    // No pop pass-through: a full queue refuses even if it pops this cycle.
    memReady = rst_n && (count < CW'(FIFO_DEPTH));
    alu_win  = rst_n && aluValid && !forced && writable(aluRd);
    q_win    = rst_n && !q_empty && !alu_win;
    push     = memValid && memReady && writable(memRd);
    q_head   = q_ent[head];
  end

  // Queue payload storage; contents are qualified by q_vld so need no reset.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      q_ent[tail] <= '{rd: memRd, data: memData};
    end
  end

  // Queue pointers, occupancy and per-slot valid bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      q_vld <= '0;
    end else begin
      if (push)  tail <= ptr_inc(tail);
      if (q_win) head <= ptr_inc(head);
      case ({push, q_win})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A push only lands on a free slot, so it never collides with the pop.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (push && (tail == PW'(i)))       q_vld[i] <= 1'b1;
        else if (q_win && (head == PW'(i))) q_vld[i] <= 1'b0;
      end
    end
  end

  // Count consecutive losses of a non-empty queue; saturate at the limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve <= '0;
    end else if (q_empty || q_win) begin
      starve <= '0;
    end else if (alu_win && (starve != 4'(STARVE_LIMIT))) begin
      starve <= starve + 4'd1;
    end
  end

  // Register the winner onto the register-file write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
    end else if (alu_win) begin
      regWrite      <= 1'b1;
      writeRegister <= aluRd;
      writeData     <= aluData;
    end else if (q_win) begin
      regWrite      <= 1'b1;
      writeRegister <= q_head.rd;
      writeData     <= q_head.data;
    end else begin
      regWrite      <= 1'b0;
    end
  end

  // Hazard lookup: every live queue slot plus the write now on the port.
  logic [FIFO_DEPTH-1:0] slot_hit1;
  logic [FIFO_DEPTH-1:0] slot_hit2;

  for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_slot
    wb_slot_match u_match (
      .vld  (q_vld[g]),
      .rd   (q_ent[g].rd),
      .qry1 (readRegister1),
      .qry2 (readRegister2),
      .hit1 (slot_hit1[g]),
      .hit2 (slot_hit2[g])
    );
  end

  // Combine slot hits and the in-flight port write; suppressed in reset.
  always_comb begin
    hazard1 = rst_n && writable(readRegister1) &&
              ((|slot_hit1) || (regWrite && (writeRegister == readRegister1)));
    hazard2 = rst_n && writable(readRegister2) &&
              ((|slot_hit2) || (regWrite && (writeRegister == readRegister2)));
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_writeback_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aluValid, memValid;
  logic        aluReady, memReady;
  logic [4:0]  aluRd, memRd, readRegister1, readRegister2;
  logic [31:0] aluData, memData;
  logic        hazard1, hazard2, regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;

  always #5 clk = ~clk;

  writeback_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .aluValid(aluValid), .aluReady(aluReady), .aluRd(aluRd), .aluData(aluData),
    .memValid(memValid), .memReady(memReady), .memRd(memRd), .memData(memData),
    .readRegister1(readRegister1), .readRegister2(readRegister2),
    .hazard1(hazard1), .hazard2(hazard2),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending memory writes in grant order, loss counter,
  // and the expected register-file port.
  logic [36:0] mq[$];
  int          m_starve = 0;
  logic        m_rw = 1'b0;
  logic [4:0]  m_wr = '0;
  logic [31:0] m_wd = '0;

  function automatic bit wr_ok(input logic [4:0] rd);
    return (rd != 5'd0) && (rd < 5'd16);
  endfunction

  function automatic bit haz_of(input logic [4:0] rr);
    if (!wr_ok(rr)) return 1'b0;
    if (m_rw && (m_wr == rr)) return 1'b1;
    foreach (mq[i]) if (mq[i][36:32] == rr) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model,
  // then check the registered port just after the edge.
  task automatic step();
    bit          forced, alu_w, q_w, push;
    logic [36:0] head;
    forced = 1'b0;
    @(negedge clk);
    if (!rst_n) begin
      chk("aluReady_rst", 32'(aluReady), 32'(1));
      chk("memReady_rst", 32'(memReady), 32'(0));
      chk("hazard1_rst", 32'(hazard1), 32'(0));
      chk("hazard2_rst", 32'(hazard2), 32'(0));
      mq.delete();
      m_starve = 0;
      m_rw = 1'b0;
      m_wr = '0;
      m_wd = '0;
    end else begin
      forced = (mq.size() != 0) && (m_starve == LIMIT);
      chk("aluReady", 32'(aluReady), 32'(!forced));
      chk("memReady", 32'(memReady), 32'(mq.size() < DEPTH));
      chk("hazard1", 32'(hazard1), 32'(haz_of(readRegister1)));
      chk("hazard2", 32'(hazard2), 32'(haz_of(readRegister2)));
      alu_w = aluValid && !forced && wr_ok(aluRd);
      q_w   = !alu_w && (mq.size() != 0);
      push  = memValid && (mq.size() < DEPTH) && wr_ok(memRd);
      if ((mq.size() == 0) || q_w) m_starve = 0;
      else if (m_starve < LIMIT) m_starve++;
      if (alu_w) begin
        m_rw = 1'b1; m_wr = aluRd; m_wd = aluData;
      end else if (q_w) begin
        head = mq.pop_front();
        m_rw = 1'b1; m_wr = head[36:32]; m_wd = head[31:0];
      end else begin
        m_rw = 1'b0;
      end
      if (push) mq.push_back({memRd, memData});
    end
    @(posedge clk);
    #1;
    chk("regWrite", 32'(regWrite), 32'(m_rw));
    chk("writeRegister", 32'(writeRegister), 32'(m_wr));
    chk("writeData", writeData, m_wd);
  endtask

  task automatic idle();
    aluValid = 1'b0; memValid = 1'b0;
    aluRd = '0; memRd = '0; aluData = '0; memData = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    readRegister1 = '0; readRegister2 = '0;

    // reset state
    step();
    step();
    chk("rst_regWrite", 32'(regWrite), 32'(0));
    chk("rst_writeData", writeData, 32'h0);
    rst_n = 1'b1;
    step();

    // ALU only
    aluValid = 1'b1; aluRd = 5'd5; aluData = 32'hDEADBEEF;
    step();
    chk("alu_only_rw", 32'(regWrite), 32'(1));
    chk("alu_only_wr", 32'(writeRegister), 32'd5);
    chk("alu_only_wd", writeData, 32'hDEADBEEF);
    idle();
    step();

    // simultaneous ALU + memory, hazard on r7 until it retires
    aluValid = 1'b1; aluRd = 5'd3; aluData = 32'h11;
    memValid = 1'b1; memRd = 5'd7; memData = 32'h22;
    readRegister1 = 5'd7; readRegister2 = 5'd3;
    step();
    chk("simul_wr1", 32'(writeRegister), 32'd3);
    chk("simul_haz7_queued", 32'(hazard1), 32'(1));
    idle();
    step();
    chk("simul_wr2", 32'(writeRegister), 32'd7);
    chk("simul_wd2", writeData, 32'h22);
    chk("simul_haz7_port", 32'(hazard1), 32'(1));
    step();
    chk("simul_haz7_clear", 32'(hazard1), 32'(0));

    // non-writable destinations are dropped
    aluValid = 1'b1; aluRd = 5'd0; aluData = 32'h55;
    memValid = 1'b1; memRd = 5'd20; memData = 32'h66;
    step();
    chk("drop_rw", 32'(regWrite), 32'(0));
    idle();
    step();
    chk("drop_memReady", 32'(memReady), 32'(1));

    // starvation: r9 queued behind continuous ALU traffic
    aluValid = 1'b1; aluRd = 5'd1; aluData = 32'hA0;
    memValid = 1'b1; memRd = 5'd9; memData = 32'h99;
    step();
    memValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      aluData = 32'hA1 + 32'(k);
      step();
      chk("starve_alu_win", 32'(writeRegister), 32'd1);
    end
    step();
    chk("starve_forced_wr", 32'(writeRegister), 32'd9);
    chk("starve_forced_wd", writeData, 32'h99);
    idle();
    step();

    // full queue under continuous ALU traffic
    aluValid = 1'b1; aluRd = 5'd2;
    memValid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      aluData = 32'h100 + 32'(k);
      memRd = 5'(10 + (k % 5)); memData = 32'h200 + 32'(k);
      step();
    end
    idle();
    for (int k = 0; k < 6; k++) step();

    // reset mid-stream discards queued writes
    memValid = 1'b1; aluValid = 1'b1; aluRd = 5'd4;
    for (int k = 0; k < 3; k++) begin
      memRd = 5'(11 + k); memData = 32'h300 + 32'(k);
      step();
    end
    idle();
    rst_n = 1'b0;
    step();
    chk("midrst_rw", 32'(regWrite), 32'(0));
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("midrst_no_write", 32'(regWrite), 32'(0));
    end

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst_n         = ($urandom_range(0, 60) != 0);
      aluValid      = ($urandom_range(0, 3) != 0);
      aluRd         = 5'($urandom_range(0, 19));
      aluData       = $urandom;
      memValid      = ($urandom_range(0, 2) != 0);
      memRd         = 5'($urandom_range(0, 19));
      memData       = $urandom;
      readRegister1 = 5'($urandom_range(0, 17));
      readRegister2 = 5'($urandom_range(0, 17));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, memory-side write queue depth; legal values 2, 4, 8.
REQ-002 Parameter STARVE_LIMIT, default 3, consecutive cycles a non-empty queue may lose arbitration before it is forced; legal range 1-15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 aluValid  input  1  ALU-path write request.
REQ-006 aluReady  output  1  ALU-path request accepted this cycle.
REQ-007 aluRd  input  5  ALU-path destination register.
REQ-008 aluData  input  32  ALU-path write data.
REQ-009 memValid  input  1  memory/long-latency write request.
REQ-010 memReady  output  1  queue can accept memory write.
REQ-011 memRd  input  5  memory-path destination register.
REQ-012 memData  input  32  memory-path write data.
REQ-013 readRegister1  input  5  decode-stage source 1, hazard query.
REQ-014 readRegister2  input  5  decode-stage source 2, hazard query.
REQ-015 hazard1  output  1  write to readRegister1 still pending.
REQ-016 hazard2  output  1  write to readRegister2 still pending.
REQ-017 regWrite  output  1  register-file write enable, registered.
REQ-018 writeRegister  output  5  register-file write address, registered.
REQ-019 writeData  output  32  register-file write data, registered.

Function
REQ-020 Destination is writable only if rd != 0 and rd[4] == 0 (16-entry file); non-writable requests complete the handshake and produce no regWrite.
REQ-021 ALU handshake: accept when aluValid && aluReady; memory handshake: accept when memValid && memReady.
REQ-022 memReady = (queue count < FIFO_DEPTH) && rst_n; purely from registered state, no same-cycle pop pass-through.
REQ-023 Accepted memory writes with writable rd are pushed in order; non-writable ones are dropped, not stored.
REQ-024 Arbitration each cycle, one winner max: forced if queue non-empty and starve counter == STARVE_LIMIT, then queue head wins and aluReady = 0; otherwise aluReady = 1 and an accepted writable ALU request wins; otherwise queue head wins if non-empty.
REQ-025 Winner is registered into regWrite/writeRegister/writeData at the next edge (latency 1 cycle); no winner -> regWrite = 0, writeRegister/writeData hold.
REQ-026 Queue pops only when its head wins; push and pop in the same cycle leave count unchanged.
REQ-027 Starve counter: cleared when queue empty or queue wins; incremented when queue non-empty and ALU wins; saturates at STARVE_LIMIT.
REQ-028 A cycle where the queue is non-empty and there is no writable ALU request grants the queue regardless of counter.
REQ-029 hazardN = 1 iff readRegisterN writable and equals rd of any valid queue entry, or equals writeRegister while regWrite = 1; combinational.
REQ-030 Same-rd ordering: writes reach the register file in grant order; later grant overwrites earlier.
REQ-031 Queue pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.

Reset
REQ-032 While rst_n = 0 at an edge: queue emptied, starve counter 0, regWrite 0, writeRegister 0, writeData 0.
REQ-033 While rst_n = 0: memReady = 0, aluReady = 1, hazard1 = hazard2 = 0; inputs ignored.
REQ-034 Reset asserted mid-operation discards all queued writes; no regWrite is produced for them after release.

Verification
REQ-035 ALU only: aluValid=1, aluRd=5, aluData=0xDEADBEEF -> next cycle regWrite=1, writeRegister=5, writeData=0xDEADBEEF.
REQ-036 Simultaneous: ALU rd=3 data=0x11, mem rd=7 data=0x22, queue empty -> cycle+1 writes r3=0x11, cycle+2 writes r7=0x22; hazard for 7 high until that write retires.
REQ-037 Full queue: push 4 mem writes with ALU idle held off by continuous ALU traffic -> memReady=0 after 4th push; 5th held until a pop, then accepted.
REQ-038 Starvation: queue holds rd=9, ALU valid every cycle, STARVE_LIMIT=3 -> 3 ALU writes, then aluReady=0 for one cycle and r9 written.
REQ-039 Drop: aluRd=0 and memRd=20 accepted -> no regWrite, queue count stays 0.
REQ-040 Reset mid-stream: 3 queued writes, rst_n=0 for 1 cycle -> regWrite=0, count=0, no further writes after release.
